bbox_frame_ctrl: RTL and testbench

BBOX_FRAME_CTRL -- requirements
Module: bbox_frame_ctrl

---
 rtl/bbox_pkg.sv | 15 +
 rtl/bbox_frame_ctrl_if.sv | 26 ++
 rtl/bbox_xy_counter.sv | 45 ++++
 rtl/bbox_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_bbox_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bbox_pkg.sv
// Shared field widths and controller state encoding for the bbox frame controller.
package bbox_pkg;

   localparam int WIDTH_BITS  = 11;
   localparam int HEIGHT_BITS = 10;
   localparam int LABEL_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/bbox_frame_ctrl_if.sv
// Link between the frame controller (master) and the downstream bbox unit (slave).
interface bbox_frame_ctrl_if #(
   parameter int WIDTH_BITS  = bbox_pkg::WIDTH_BITS,
   parameter int HEIGHT_BITS = bbox_pkg::HEIGHT_BITS,
   parameter int LABEL_WIDTH = bbox_pkg::LABEL_WIDTH
) ();

   logic                   bbox_enable;
   logic                   bbox_motion_pixel;
   logic                   bbox_last_in_frame;
   logic [WIDTH_BITS-1:0]  bbox_width;
   logic [HEIGHT_BITS-1:0] bbox_height;
   logic                   bbox_valid;
   logic [LABEL_WIDTH-1:0] bbox_label;

   modport master (
      output bbox_enable, bbox_motion_pixel, bbox_last_in_frame, bbox_width, bbox_height,
      input  bbox_valid, bbox_label
   );

   modport slave (
      input  bbox_enable, bbox_motion_pixel, bbox_last_in_frame, bbox_width, bbox_height,
      output bbox_valid, bbox_label
   );

endinterface

// File: rtl/bbox_xy_counter.sv
// Raster position counter: x wraps at width-1 and bumps y; flags the final pixel of the frame.
module bbox_xy_counter #(
   parameter int WIDTH_BITS  = 11,
   parameter int HEIGHT_BITS = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   advance,
   input  logic [WIDTH_BITS-1:0]  width,
   input  logic [HEIGHT_BITS-1:0] height,
   output logic [WIDTH_BITS-1:0]  x,
   output logic [HEIGHT_BITS-1:0] y,
   output logic                   last
);

   logic [WIDTH_BITS-1:0]  x_reg;
   logic [HEIGHT_BITS-1:0] y_reg;
   logic                   x_end;
   logic                   y_end;

   assign x_end = (x_reg == width - WIDTH_BITS'(1));
   assign y_end = (y_reg == height - HEIGHT_BITS'(1));
   assign last  = x_end & y_end;
   assign x     = x_reg;
   assign y     = y_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (clear) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (advance) begin
         if (x_end) begin
            x_reg <= '0;
            y_reg <= y_end ? '0 : y_reg + HEIGHT_BITS'(1);
         end else begin
            x_reg <= x_reg + WIDTH_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/bbox_frame_ctrl.sv
// Frame sequencer: accepts a config, streams one frame of motion pixels to the bbox unit,
// waits for box records to go quiet, then pulses frame_done. Counts boxes per frame.
module bbox_frame_ctrl #(
   parameter int WIDTH_BITS  = bbox_pkg::WIDTH_BITS,
   parameter int HEIGHT_BITS = bbox_pkg::HEIGHT_BITS,
   parameter int LABEL_WIDTH = bbox_pkg::LABEL_WIDTH,
   parameter int DRAIN_IDLE  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WIDTH_BITS-1:0]  cfg_width,
   input  logic [HEIGHT_BITS-1:0] cfg_height,
   input  logic                   pix_valid,
   input  logic                   pix_motion,
   output logic                   pix_ready,
   bbox_frame_ctrl_if.master      bus,
   output logic                   busy,
   output logic [LABEL_WIDTH-1:0] box_count,
   output logic                   box_overflow,
   output logic                   frame_done,
   output logic                   cfg_err
);
   import bbox_pkg::*;

   localparam int                     IDLE_W    = $clog2(DRAIN_IDLE + 1);
   localparam logic [IDLE_W-1:0]      IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);
   localparam logic [LABEL_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state_reg, state_next;
   logic                   load, reject, accept, counting, xy_last;
   logic [WIDTH_BITS-1:0]  width_reg, x_cur;
   logic [HEIGHT_BITS-1:0] height_reg, y_cur;
   logic [IDLE_W-1:0]      idle_cnt_reg;
   logic [LABEL_WIDTH-1:0] box_count_reg;
   logic                   box_overflow_reg, enable_reg, motion_reg, last_reg, cfg_err_reg;
   logic                   unused_monitor;

   assign pix_ready = (state_reg == ST_STREAM);
   assign accept    = pix_valid & pix_ready;
   assign counting  = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      reject     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (cfg_width != '0 && cfg_height != '0) begin
                  load       = 1'b1;
                  state_next = ST_STREAM;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_STREAM: if (accept && xy_last) state_next = ST_DRAIN;
         // A box record arriving on the timeout cycle keeps the drain alive.
         ST_DRAIN:  if (!bus.bbox_valid && idle_cnt_reg == IDLE_LAST) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         width_reg        <= '0;
         height_reg       <= '0;
         idle_cnt_reg     <= '0;
         box_count_reg    <= '0;
         box_overflow_reg <= 1'b0;
         enable_reg       <= 1'b0;
         motion_reg       <= 1'b0;
         last_reg         <= 1'b0;
         cfg_err_reg      <= 1'b0;
      end else begin
         enable_reg  <= accept;
         motion_reg  <= accept & pix_motion;
         last_reg    <= accept & xy_last;
         cfg_err_reg <= reject;
         if (load) begin
            width_reg        <= cfg_width;
            height_reg       <= cfg_height;
            idle_cnt_reg     <= '0;
            box_count_reg    <= '0;
            box_overflow_reg <= 1'b0;
         end else begin
            if (counting && bus.bbox_valid) begin
               if (box_count_reg == COUNT_MAX) box_overflow_reg <= 1'b1;
               else                            box_count_reg    <= box_count_reg + LABEL_WIDTH'(1);
            end
            if (state_reg == ST_DRAIN)
               idle_cnt_reg <= bus.bbox_valid ? '0 : idle_cnt_reg + IDLE_W'(1);
         end
      end
   end

   bbox_xy_counter #(
      .WIDTH_BITS  (WIDTH_BITS),
      .HEIGHT_BITS (HEIGHT_BITS)
   ) u_xy (
      .clk     (clk),
      .rst     (rst),
      .clear   (load),
      .advance (accept),
      .width   (width_reg),
      .height  (height_reg),
      .x       (x_cur),
      .y       (y_cur),
      .last    (xy_last)
   );

   assign bus.bbox_enable        = enable_reg;
   assign bus.bbox_motion_pixel  = motion_reg;
   assign bus.bbox_last_in_frame = last_reg;
   assign bus.bbox_width         = width_reg;
   assign bus.bbox_height        = height_reg;
   assign busy                   = (state_reg != ST_IDLE);
   assign box_count              = box_count_reg;
   assign box_overflow           = box_overflow_reg;
   assign frame_done             = (state_reg == ST_DONE);
   assign cfg_err                = cfg_err_reg;

   // Label is observed by the bbox unit's consumers; x/y are exposed for debug visibility.
   assign unused_monitor = ^{bus.bbox_label, x_cur, y_cur};

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// Directed bench for bbox_frame_ctrl: config reject, full/throttled frames, box saturation,
// drain timeout restart, 1x1 frame and mid-frame reset recovery.
module tb_bbox_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] cfg_width;
   logic [9:0]  cfg_height;
   logic        pix_valid;
   logic        pix_motion;
   logic        pix_ready;
   logic        busy;
   logic [7:0]  box_count;
   logic        box_overflow;
   logic        frame_done;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   bbox_frame_ctrl_if bus_if ();

   bbox_frame_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .pix_valid    (pix_valid),
      .pix_motion   (pix_motion),
      .pix_ready    (pix_ready),
      .bus          (bus_if),
      .busy         (busy),
      .box_count    (box_count),
      .box_overflow (box_overflow),
      .frame_done   (frame_done),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles until frame_done, bounded so a stuck drain still reaches the summary.
   task automatic wait_done(input int exp_cycles, input string tag);
      int c;
      c = 0;
      do begin
         step();
         c++;
      end while (!frame_done && c < 40);
      check(tag, c, exp_cycles);
   endtask

   initial begin
      logic [7:0] mpat;
      int n, k;
      mpat = 8'b1011_0010;

      rst = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
      pix_valid = 1'b0; pix_motion = 1'b0;
      bus_if.bbox_valid = 1'b0; bus_if.bbox_label = '0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_ready", pix_ready, 0);
      check("rst_enable", bus_if.bbox_enable, 0);
      check("rst_width", bus_if.bbox_width, 0);
      check("rst_count", box_count, 0);
      check("rst_done", frame_done, 0);
      check("rst_cfg_err", cfg_err, 0);
      rst = 1'b1;
      step();

      // zero-width start is rejected
      start = 1'b1; cfg_width = 11'd0; cfg_height = 10'd2;
      step();
      check("zero_cfg_err", cfg_err, 1);
      check("zero_busy", busy, 0);
      check("zero_ready", pix_ready, 0);
      check("zero_width_kept", bus_if.bbox_width, 0);
      start = 1'b0;
      step();
      check("zero_cfg_err_pulse", cfg_err, 0);
      check("zero_busy_after", busy, 0);
      $display("frame reject: cfg_err pulse observed, busy=%0b", busy);

      // 4x2 frame, pix_valid held high
      cfg_width = 11'd4; cfg_height = 10'd2; start = 1'b1; pix_valid = 1'b1;
      step();
      check("full_busy", busy, 1);
      check("full_width", bus_if.bbox_width, 4);
      check("full_height", bus_if.bbox_height, 2);
      check("full_enable_pre", bus_if.bbox_enable, 0);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pix_motion = mpat[i];
         check("full_x", dut.x_cur, i % 4);
         check("full_y", dut.y_cur, i / 4);
         step();
         check("full_enable", bus_if.bbox_enable, 1);
         check("full_motion", bus_if.bbox_motion_pixel, mpat[i]);
         check("full_last", bus_if.bbox_last_in_frame, (i == 7) ? 1 : 0);
      end
      check("full_drain_ready", pix_ready, 0);
      pix_valid = 1'b0;
      wait_done(16, "full_done_latency");
      check("full_enable_idle", bus_if.bbox_enable, 0);
      step();
      check("full_done_pulse", frame_done, 0);
      check("full_busy_end", busy, 0);
      $display("frame 4x2 full: box_count=%0d", box_count);

      // 4x2 frame, pix_valid toggled; start/cfg changes mid-frame must be ignored
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0; k = 0;
      while (n < 8 && k < 40) begin
         pix_valid  = (k % 2 == 0);
         start      = (k == 2 || k == 3);
         cfg_width  = (k == 2 || k == 3) ? 11'd7 : 11'd4;
         pix_motion = n[0];
         check("tog_ready", pix_ready, 1);
         check("tog_x", dut.x_cur, n % 4);
         check("tog_y", dut.y_cur, n / 4);
         step();
         check("tog_enable", bus_if.bbox_enable, pix_valid);
         if (pix_valid) begin
            check("tog_motion", bus_if.bbox_motion_pixel, n % 2);
            check("tog_last", bus_if.bbox_last_in_frame, (n == 7) ? 1 : 0);
            n++;
         end
         k++;
      end
      start = 1'b0; cfg_width = 11'd4; pix_valid = 1'b0;
      check("tog_width_held", bus_if.bbox_width, 4);
      wait_done(16, "tog_done_latency");
      step();
      $display("frame 4x2 toggled: accepted=%0d cycles=%0d", n, k);

      // 300 box records in one frame saturate the count
      start = 1'b1;
      step();
      start = 1'b0;
      bus_if.bbox_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 1)   check("sat_first", box_count, 1);
         if (i == 255) check("sat_255_count", box_count, 255);
         if (i == 255) check("sat_255_ovf", box_overflow, 0);
         if (i == 256) check("sat_256_ovf", box_overflow, 1);
      end
      bus_if.bbox_valid = 1'b0;
      pix_valid = 1'b1;
      repeat (8) step();
      pix_valid = 1'b0;
      check("sat_drain_ready", pix_ready, 0);
      wait_done(16, "sat_done_latency");
      check("sat_count", box_count, 255);
      check("sat_ovf", box_overflow, 1);
      step();
      bus_if.bbox_valid = 1'b1;
      step();
      bus_if.bbox_valid = 1'b0;
      check("sat_hold_count", box_count, 255);
      check("sat_hold_ovf", box_overflow, 1);
      check("sat_idle_busy", busy, 0);
      $display("frame 4x2 saturate: box_count=%0d overflow=%0b", box_count, box_overflow);

      // 1x1 frame with a box record landing on the timeout cycle
      cfg_width = 11'd1; cfg_height = 10'd1; start = 1'b1; pix_valid = 1'b1;
      step();
      start = 1'b0;
      check("one_ready", pix_ready, 1);
      check("one_ovf_cleared", box_overflow, 0);
      step();
      check("one_enable", bus_if.bbox_enable, 1);
      check("one_last", bus_if.bbox_last_in_frame, 1);
      check("one_drain_ready", pix_ready, 0);
      pix_valid = 1'b0;
      repeat (15) step();
      check("one_no_done_yet", frame_done, 0);
      bus_if.bbox_valid = 1'b1;
      step();
      check("one_timeout_blocked", frame_done, 0);
      check("one_timeout_busy", busy, 1);
      check("one_count", box_count, 1);
      bus_if.bbox_valid = 1'b0;
      wait_done(16, "one_restart_latency");
      check("one_final_count", box_count, 1);
      step();
      $display("frame 1x1 late box: box_count=%0d", box_count);

      // reset mid-STREAM, then a clean 2x2 frame started on the first edge after release
      cfg_width = 11'd4; cfg_height = 10'd2; start = 1'b1; pix_valid = 1'b1;
      step();
      start = 1'b0;
      bus_if.bbox_valid = 1'b1;
      step();
      step();
      bus_if.bbox_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", pix_ready, 0);
      check("mid_rst_enable", bus_if.bbox_enable, 0);
      check("mid_rst_motion", bus_if.bbox_motion_pixel, 0);
      check("mid_rst_last", bus_if.bbox_last_in_frame, 0);
      check("mid_rst_width", bus_if.bbox_width, 0);
      check("mid_rst_height", bus_if.bbox_height, 0);
      check("mid_rst_count", box_count, 0);
      check("mid_rst_x", dut.x_cur, 0);
      step();
      rst = 1'b1; cfg_width = 11'd2; cfg_height = 10'd2; start = 1'b1; pix_valid = 1'b1;
      step();
      start = 1'b0;
      check("post_rst_busy", busy, 1);
      check("post_rst_width", bus_if.bbox_width, 2);
      for (int i = 0; i < 4; i++) begin
         pix_motion = i[0];
         check("post_x", dut.x_cur, i % 2);
         check("post_y", dut.y_cur, i / 2);
         step();
         check("post_enable", bus_if.bbox_enable, 1);
         check("post_last", bus_if.bbox_last_in_frame, (i == 3) ? 1 : 0);
      end
      pix_valid = 1'b0;
      wait_done(16, "post_done_latency");
      check("post_count", box_count, 0);
      step();
      $display("frame 2x2 after reset: box_count=%0d", box_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
